branch_resolution_queue: RTL and testbench
==========================================

Name: branch_resolution_queue

Overview:
- In-order queue of in-flight branch/jump predictions, between decode (allocate) and the execute branch unit (resolve).
- Compares each resolved outcome with the stored prediction and issues a front-end redirect on a mispredict.
- Squashes younger entries on a mispredict.
- Retires resolved entries in program order as per-slot update vectors (pc, actual next PC, mispredict) that train the branch predictor.

Parameters:
- SUPER, 2, decode/retire slots per cycle.
- BRQ_DEPTH, 8, entries; power of two, >= SUPER.
- TAG_W, $clog2(BRQ_DEPTH), entry tag width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- alloc_valid  in  SUPER  slot i is a branch/jump to enqueue
- alloc_pc  in  SUPER x 32  PC of slot i
- alloc_pred_taken  in  SUPER  predicted direction
- alloc_pred_target  in  SUPER x 32  predicted next PC when taken
- alloc_ready  out  1  free entries >= SUPER
- alloc_tag  out  SUPER x TAG_W  tag assigned to slot i (valid when alloc_valid[i])
- resolve_valid  in  1  one branch resolved this cycle
- resolve_tag  in  TAG_W  entry being resolved
- resolve_taken  in  1  actual direction
- resolve_target  in  32  actual target when taken
- redirect_valid  out  1  one-cycle pulse: fetch must restart
- redirect_pc  out  32  correct next PC
- upd_valid  out  SUPER  retire slot k carries an update
- upd_pc  out  SUPER x 32  PC of retired branch
- actual_nextpc  out  SUPER x 32  resolved next PC
- mispredict  out  SUPER  retired branch was mispredicted

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- On reset: all entries EMPTY; head = tail = 0; count = 0. All registered outputs are 0; alloc_ready = 1.
- Pointers carry TAG_W+1 bits, with the MSB as the wrap bit. Full when count == BRQ_DEPTH, empty when count == 0. Index arithmetic wraps modulo BRQ_DEPTH.
- Entry states: EMPTY -> PENDING (alloc) -> RESOLVED (resolve) -> EMPTY (retire or squash).
- Alloc:
  - alloc_ready = (BRQ_DEPTH - count) >= SUPER, computed from registered count only; same-cycle retire does not raise it.
  - When alloc_ready is high, slots with alloc_valid set are written at consecutive tail positions, compacted, in slot order.
  - alloc_tag[i] = tail + (number of set alloc_valid bits below i); combinational.
  - tail and count advance by popcount(alloc_valid).
  - alloc_valid while alloc_ready is low is ignored.
- Resolve (registered):
  - Accepted only if resolve_tag is PENDING; otherwise ignored.
  - actual = resolve_taken ? resolve_target : pc + 4 (32-bit, wraps).
  - mis = (resolve_taken != pred_taken) | (resolve_taken & (resolve_target != pred_target)).
  - Entry becomes RESOLVED and stores actual and mis.
  - If mis: redirect_valid = 1 and redirect_pc = actual in the cycle after resolve, for exactly one cycle.
- Squash on mispredict:
  - Same edge as the resolve: all entries younger than resolve_tag become EMPTY.
  - tail = resolve_tag + 1, with the wrap bit preserved relative to head; count recomputed.
  - Any alloc in the same cycle is dropped.
  - A resolve of a younger, already-squashed tag in the same cycle cannot occur, since only one resolve is allowed per cycle.
- Retire:
  - Each cycle, up to SUPER consecutive RESOLVED entries starting at head are retired; stops at the first non-RESOLVED entry.
  - Outputs are registered: upd_valid, upd_pc, actual_nextpc and mispredict appear the cycle after the retire decision, in slot k = age order.
  - Unused slots have upd_valid = 0 and the other fields 0.
  - Retired entries become EMPTY; head advances.
- Latency:
  - Resolve at edge N: redirect visible after edge N.
  - If the entry is at head, upd_* visible after edge N+1.
- Simultaneous alloc + retire + non-mispredict resolve: all apply. count = count + allocs - retires.
- Reset mid-operation: all entries dropped; no redirect or update emitted.

Optional Feature:
- BRQ_STATS_EN defined:
  - Two 32-bit saturating counters, stat_branches and stat_mispredicts (output ports), incremented per retired entry and per retired mispredict.
  - Cleared by rst.
- Not defined: the ports exist and are tied to 0; no counter logic.

Decomposition:
- brq_pkg holds:
  - brq_state_e (EMPTY/PENDING/RESOLVED)
  - brq_entry_t (pc, pred_taken, pred_target, actual, mis, state)
  - TAG_W derivation
- Sub-module brq_mispredict_check: combinational compare producing actual and mis from an entry plus the resolve inputs.

Test Plan:
- Reset, then alloc slot0 pc=0x100, pred_taken=0; resolve tag0 taken=0 -> no redirect; next cycle upd_valid=01, actual_nextpc[0]=0x104, mispredict=0.
- Alloc pc=0x200, pred_taken=1, pred_target=0x400; resolve taken=1, target=0x480 -> redirect_valid pulse with redirect_pc=0x480; retire mispredict[0]=1, actual_nextpc=0x480.
- Fill 8 entries (4 cycles x 2) -> alloc_ready=0 when 7 or 8 entries are used; further alloc ignored; retire 2 -> alloc_ready=1 again.
- Entries tags 0..4 pending; resolve tag1 mispredict with alloc of 2 in the same cycle -> tags 2..4 EMPTY, tail=2, the same-cycle alloc is dropped, count=2.
- Resolve tag1 before tag0 -> no retire until tag0 resolves; then both retire in the same cycle with slot0=tag0, slot1=tag1.
- Wrap: run 20 alloc/resolve/retire cycles -> pointers wrap; tags reused modulo 8; no lost or duplicated updates.

Source files
------------

// File: rtl/brq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : brq_pkg                                                       |
// | Purpose  : Shared types for the branch resolution queue.                 |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package brq_pkg;

    localparam int unsigned C_BRQ_DEPTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        PENDING  = 2'd1,
        RESOLVED = 2'd2
    } brq_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic [31:0] actual;
        logic        mis;
        brq_state_e  state;
    } brq_entry_t;

    function automatic int unsigned brq_tag_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/brq_mispredict_check.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : brq_mispredict_check                                          |
// | Purpose  : Resolved next PC and mispredict flag for one queue entry.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module brq_mispredict_check (
    input  logic [31:0] entry_pc,
    input  logic        entry_pred_taken,
    input  logic [31:0] entry_pred_target,
    input  logic        resolve_taken,
    input  logic [31:0] resolve_target,
    output logic [31:0] actual,
    output logic        mis
);

    assign actual = resolve_taken ? resolve_target : (entry_pc + 32'd4);

    // A correctly predicted taken branch still mispredicts if the target differs.
    assign mis = (resolve_taken != entry_pred_taken) |
                 (resolve_taken & (resolve_target != entry_pred_target));

endmodule
`default_nettype wire

// File: rtl/branch_resolution_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : branch_resolution_queue                                       |
// | Purpose  : In-order branch queue: resolve, redirect, squash, retire.     |
// |            Define BRQ_STATS_EN to enable retire/mispredict counters.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module branch_resolution_queue
    import brq_pkg::*;
#(
    parameter int unsigned SUPER     = 2,
    parameter int unsigned BRQ_DEPTH = C_BRQ_DEPTH_DEFAULT,
    parameter int unsigned TAG_W     = brq_tag_w(BRQ_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SUPER-1:0]            alloc_valid,
    input  logic [SUPER-1:0][31:0]      alloc_pc,
    input  logic [SUPER-1:0]            alloc_pred_taken,
    input  logic [SUPER-1:0][31:0]      alloc_pred_target,
    output logic                        alloc_ready,
    output logic [SUPER-1:0][TAG_W-1:0] alloc_tag,
    input  logic                        resolve_valid,
    input  logic [TAG_W-1:0]            resolve_tag,
    input  logic                        resolve_taken,
    input  logic [31:0]                 resolve_target,
    output logic                        redirect_valid,
    output logic [31:0]                 redirect_pc,
    output logic [SUPER-1:0]            upd_valid,
    output logic [SUPER-1:0][31:0]      upd_pc,
    output logic [SUPER-1:0][31:0]      actual_nextpc,
    output logic [SUPER-1:0]            mispredict,
    output logic [31:0]                 stat_branches,
    output logic [31:0]                 stat_mispredicts
);

    localparam int unsigned     C_PTR_W = TAG_W + 1;
    localparam logic [C_PTR_W-1:0] C_DEPTH = C_PTR_W'(BRQ_DEPTH);
    localparam logic [C_PTR_W-1:0] C_SUPER = C_PTR_W'(SUPER);

    brq_entry_t                  r_entries [BRQ_DEPTH];
    logic [C_PTR_W-1:0]          r_head;
    logic [C_PTR_W-1:0]          r_tail;
    logic [C_PTR_W-1:0]          r_count;
    logic                        r_redirect_valid;
    logic [31:0]                 r_redirect_pc;
    logic [SUPER-1:0]            r_upd_valid;
    logic [SUPER-1:0][31:0]      r_upd_pc;
    logic [SUPER-1:0][31:0]      r_actual_nextpc;
    logic [SUPER-1:0]            r_mispredict;

    logic [SUPER-1:0][TAG_W-1:0] w_alloc_idx;
    logic [C_PTR_W-1:0]          w_n_alloc;
    logic [C_PTR_W-1:0]          w_alloc_cnt;
    logic                        w_alloc_en;
    logic                        w_res_accept;
    logic [31:0]                 w_res_actual;
    logic                        w_res_mis;
    logic                        w_squash;
    logic [TAG_W-1:0]            w_res_off;
    logic [BRQ_DEPTH-1:0]        w_squash_mask;
    logic [SUPER-1:0]            w_ret_mask;
    logic [SUPER-1:0][TAG_W-1:0] w_ret_idx;
    logic [C_PTR_W-1:0]          w_n_ret;

    // Admission looks only at the registered count; this cycle's retires do not help.
    assign alloc_ready = (C_DEPTH - r_count) >= C_SUPER;

    always_comb begin
        w_n_alloc = '0;
        for (int i = 0; i < SUPER; i++) begin
            w_alloc_idx[i] = r_tail[TAG_W-1:0] + w_n_alloc[TAG_W-1:0];
            w_n_alloc      = w_n_alloc + C_PTR_W'(alloc_valid[i]);
        end
    end

    assign alloc_tag   = w_alloc_idx;
    assign w_alloc_en  = alloc_ready & ~w_squash;
    assign w_alloc_cnt = w_alloc_en ? w_n_alloc : '0;

    assign w_res_accept = resolve_valid && (r_entries[resolve_tag].state == PENDING);

    brq_mispredict_check u_mispredict_check (
        .entry_pc          (r_entries[resolve_tag].pc),
        .entry_pred_taken  (r_entries[resolve_tag].pred_taken),
        .entry_pred_target (r_entries[resolve_tag].pred_target),
        .resolve_taken     (resolve_taken),
        .resolve_target    (resolve_target),
        .actual            (w_res_actual),
        .mis               (w_res_mis)
    );

    assign w_squash  = w_res_accept & w_res_mis;
    assign w_res_off = resolve_tag - r_head[TAG_W-1:0];

    // Age relative to head decides which entries are younger than the mispredict.
    always_comb begin
        for (int j = 0; j < BRQ_DEPTH; j++) begin
            w_squash_mask[j] = w_squash && ((TAG_W'(j) - r_head[TAG_W-1:0]) > w_res_off);
        end
    end

    always_comb begin
        logic v_run;
        v_run      = 1'b1;
        w_ret_mask = '0;
        w_n_ret    = '0;
        for (int k = 0; k < SUPER; k++) begin
            w_ret_idx[k]  = r_head[TAG_W-1:0] + TAG_W'(k);
            v_run         = v_run & (r_entries[w_ret_idx[k]].state == RESOLVED);
            w_ret_mask[k] = v_run;
            w_n_ret       = w_n_ret + C_PTR_W'(v_run);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < BRQ_DEPTH; j++) begin
                r_entries[j] <= '0;
            end
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_upd_valid      <= '0;
            r_upd_pc         <= '0;
            r_actual_nextpc  <= '0;
            r_mispredict     <= '0;
        end else begin
            for (int k = 0; k < SUPER; k++) begin
                r_upd_valid[k]     <= w_ret_mask[k];
                r_upd_pc[k]        <= w_ret_mask[k] ? r_entries[w_ret_idx[k]].pc : 32'd0;
                r_actual_nextpc[k] <= w_ret_mask[k] ? r_entries[w_ret_idx[k]].actual : 32'd0;
                r_mispredict[k]    <= w_ret_mask[k] & r_entries[w_ret_idx[k]].mis;
                if (w_ret_mask[k]) begin
                    r_entries[w_ret_idx[k]].state <= EMPTY;
                end
            end

            if (w_alloc_en) begin
                for (int i = 0; i < SUPER; i++) begin
                    if (alloc_valid[i]) begin
                        r_entries[w_alloc_idx[i]] <= '{pc:          alloc_pc[i],
                                                       pred_taken:  alloc_pred_taken[i],
                                                       pred_target: alloc_pred_target[i],
                                                       actual:      32'd0,
                                                       mis:         1'b0,
                                                       state:       PENDING};
                    end
                end
            end

            if (w_res_accept) begin
                r_entries[resolve_tag].actual <= w_res_actual;
                r_entries[resolve_tag].mis    <= w_res_mis;
                r_entries[resolve_tag].state  <= RESOLVED;
            end

            for (int j = 0; j < BRQ_DEPTH; j++) begin
                if (w_squash_mask[j]) begin
                    r_entries[j].state <= EMPTY;
                end
            end

            r_redirect_valid <= w_squash;
            r_redirect_pc    <= w_squash ? w_res_actual : 32'd0;

            r_head <= r_head + w_n_ret;
            if (w_squash) begin
                // Tail rebuilt from head so the wrap bit stays consistent.
                r_tail  <= r_head + {1'b0, w_res_off} + C_PTR_W'(1);
                r_count <= {1'b0, w_res_off} + C_PTR_W'(1) - w_n_ret;
            end else begin
                r_tail  <= r_tail + w_alloc_cnt;
                r_count <= r_count + w_alloc_cnt - w_n_ret;
            end
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign upd_valid      = r_upd_valid;
    assign upd_pc         = r_upd_pc;
    assign actual_nextpc  = r_actual_nextpc;
    assign mispredict     = r_mispredict;

`ifdef BRQ_STATS_EN
    logic [31:0]        r_stat_br;
    logic [31:0]        r_stat_mis;
    logic [C_PTR_W-1:0] w_n_ret_mis;
    logic [32:0]        w_br_sum;
    logic [32:0]        w_mis_sum;

    always_comb begin
        w_n_ret_mis = '0;
        for (int k = 0; k < SUPER; k++) begin
            w_n_ret_mis = w_n_ret_mis +
                          C_PTR_W'(w_ret_mask[k] & r_entries[w_ret_idx[k]].mis);
        end
    end

    assign w_br_sum  = {1'b0, r_stat_br}  + 33'(w_n_ret);
    assign w_mis_sum = {1'b0, r_stat_mis} + 33'(w_n_ret_mis);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_br  <= '0;
            r_stat_mis <= '0;
        end else begin
            r_stat_br  <= w_br_sum[32]  ? 32'hFFFF_FFFF : w_br_sum[31:0];
            r_stat_mis <= w_mis_sum[32] ? 32'hFFFF_FFFF : w_mis_sum[31:0];
        end
    end

    assign stat_branches    = r_stat_br;
    assign stat_mispredicts = r_stat_mis;
`else
    assign stat_branches    = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolution_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_branch_resolution_queue                                    |
// | Purpose  : Directed self-checking bench for branch_resolution_queue.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_branch_resolution_queue;

    localparam int unsigned SUPER     = 2;
    localparam int unsigned BRQ_DEPTH = 8;
    localparam int unsigned TAG_W     = 3;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [SUPER-1:0]            alloc_valid;
    logic [SUPER-1:0][31:0]      alloc_pc;
    logic [SUPER-1:0]            alloc_pred_taken;
    logic [SUPER-1:0][31:0]      alloc_pred_target;
    logic                        alloc_ready;
    logic [SUPER-1:0][TAG_W-1:0] alloc_tag;
    logic                        resolve_valid;
    logic [TAG_W-1:0]            resolve_tag;
    logic                        resolve_taken;
    logic [31:0]                 resolve_target;
    logic                        redirect_valid;
    logic [31:0]                 redirect_pc;
    logic [SUPER-1:0]            upd_valid;
    logic [SUPER-1:0][31:0]      upd_pc;
    logic [SUPER-1:0][31:0]      actual_nextpc;
    logic [SUPER-1:0]            mispredict;
    logic [31:0]                 stat_branches;
    logic [31:0]                 stat_mispredicts;

    int n_tests = 0;
    int n_fail  = 0;

    branch_resolution_queue #(
        .SUPER     (SUPER),
        .BRQ_DEPTH (BRQ_DEPTH),
        .TAG_W     (TAG_W)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .alloc_valid       (alloc_valid),
        .alloc_pc          (alloc_pc),
        .alloc_pred_taken  (alloc_pred_taken),
        .alloc_pred_target (alloc_pred_target),
        .alloc_ready       (alloc_ready),
        .alloc_tag         (alloc_tag),
        .resolve_valid     (resolve_valid),
        .resolve_tag       (resolve_tag),
        .resolve_taken     (resolve_taken),
        .resolve_target    (resolve_target),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .upd_valid         (upd_valid),
        .upd_pc            (upd_pc),
        .actual_nextpc     (actual_nextpc),
        .mispredict        (mispredict),
        .stat_branches     (stat_branches),
        .stat_mispredicts  (stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid       = '0;
        alloc_pc          = '0;
        alloc_pred_taken  = '0;
        alloc_pred_target = '0;
        resolve_valid     = 1'b0;
        resolve_tag       = '0;
        resolve_taken     = 1'b0;
        resolve_target    = '0;
    endtask

    task automatic set_alloc(input int slot, input logic [31:0] pc, input logic pt,
                             input logic [31:0] tgt);
        alloc_valid[slot]       = 1'b1;
        alloc_pc[slot]          = pc;
        alloc_pred_taken[slot]  = pt;
        alloc_pred_target[slot] = tgt;
    endtask

    task automatic do_resolve(input logic [TAG_W-1:0] tag, input logic taken,
                              input logic [31:0] tgt);
        resolve_valid  = 1'b1;
        resolve_tag    = tag;
        resolve_taken  = taken;
        resolve_target = tgt;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        check("rst_redirect", 32'(redirect_valid), 32'd0);
        check("rst_upd_valid", 32'(upd_valid), 32'd0);
        check("rst_tag0", 32'(alloc_tag[0]), 32'd0);
        check("rst_stat", stat_branches, 32'd0);

        // Correctly predicted not-taken branch
        set_alloc(0, 32'h100, 1'b0, 32'h0);
        #1 check("t1_tag", 32'(alloc_tag[0]), 32'd0);
        tick(); idle();
        do_resolve(3'd0, 1'b0, 32'h0);
        tick(); idle();
        check("t1_no_redirect", 32'(redirect_valid), 32'd0);
        tick();
        check("t1_upd_valid", 32'(upd_valid), 32'h1);
        check("t1_upd_pc", upd_pc[0], 32'h100);
        check("t1_nextpc", actual_nextpc[0], 32'h104);
        check("t1_mis", 32'(mispredict), 32'h0);

        // Taken with wrong target
        set_alloc(0, 32'h200, 1'b1, 32'h400);
        #1 check("t2_tag", 32'(alloc_tag[0]), 32'd1);
        tick(); idle();
        do_resolve(3'd1, 1'b1, 32'h480);
        tick(); idle();
        check("t2_redirect", 32'(redirect_valid), 32'd1);
        check("t2_redirect_pc", redirect_pc, 32'h480);
        tick();
        check("t2_pulse", 32'(redirect_valid), 32'd0);
        check("t2_upd_valid", 32'(upd_valid), 32'h1);
        check("t2_mis", 32'(mispredict), 32'h1);
        check("t2_nextpc", actual_nextpc[0], 32'h480);

        // Fill to 7 entries across the wrap point
        set_alloc(0, 32'h1000, 1'b0, 32'h0);
        set_alloc(1, 32'h1004, 1'b0, 32'h0);
        #1 check("fill_tag0", 32'(alloc_tag[0]), 32'd2);
        check("fill_tag1", 32'(alloc_tag[1]), 32'd3);
        tick(); idle();
        set_alloc(0, 32'h1008, 1'b0, 32'h0);
        set_alloc(1, 32'h100C, 1'b0, 32'h0);
        tick(); idle();
        set_alloc(0, 32'h1010, 1'b0, 32'h0);
        tick(); idle();
        set_alloc(0, 32'h1014, 1'b0, 32'h0);
        set_alloc(1, 32'h1018, 1'b0, 32'h0);
        #1 check("fill_wrap_tag0", 32'(alloc_tag[0]), 32'd7);
        check("fill_wrap_tag1", 32'(alloc_tag[1]), 32'd0);
        check("fill_ready5", 32'(alloc_ready), 32'd1);
        tick(); idle();
        check("fill_ready7", 32'(alloc_ready), 32'd0);
        set_alloc(0, 32'hDEAD0, 1'b0, 32'h0);
        set_alloc(1, 32'hDEAD4, 1'b0, 32'h0);
        tick(); idle();
        check("fill_still_full", 32'(alloc_ready), 32'd0);

        // Out-of-order resolve holds retire until the head resolves
        do_resolve(3'd3, 1'b0, 32'h0);
        tick(); idle();
        do_resolve(3'd2, 1'b0, 32'h0);
        tick(); idle();
        check("ooo_hold", 32'(upd_valid), 32'h0);
        tick();
        check("ooo_upd_valid", 32'(upd_valid), 32'h3);
        check("ooo_pc0", upd_pc[0], 32'h1000);
        check("ooo_pc1", upd_pc[1], 32'h1004);
        check("ooo_nextpc1", actual_nextpc[1], 32'h1008);
        check("ooo_ready", 32'(alloc_ready), 32'd1);
        check("ignored_alloc_tail", 32'(alloc_tag[0]), 32'd1);

        // Mispredict on tag5 with a same-cycle alloc; tags 6,7,0 squashed
        do_resolve(3'd5, 1'b1, 32'h2000);
        set_alloc(0, 32'h5000, 1'b0, 32'h0);
        set_alloc(1, 32'h5004, 1'b0, 32'h0);
        tick(); idle();
        check("sq_redirect", 32'(redirect_valid), 32'd1);
        check("sq_redirect_pc", redirect_pc, 32'h2000);
        check("sq_tail", 32'(alloc_tag[0]), 32'd6);
        set_alloc(0, 32'h1100, 1'b0, 32'h0);
        set_alloc(1, 32'h1104, 1'b0, 32'h0);
        tick(); idle();
        set_alloc(0, 32'h1108, 1'b0, 32'h0);
        set_alloc(1, 32'h110C, 1'b0, 32'h0);
        tick(); idle();
        check("sq_count6_ready", 32'(alloc_ready), 32'd1);
        set_alloc(0, 32'h1110, 1'b0, 32'h0);
        set_alloc(1, 32'h1114, 1'b0, 32'h0);
        tick(); idle();
        check("sq_count8_ready", 32'(alloc_ready), 32'd0);
        do_resolve(3'd4, 1'b0, 32'h0);
        tick(); idle();
        tick();
        check("sq_upd_valid", 32'(upd_valid), 32'h3);
        check("sq_mis", 32'(mispredict), 32'h2);
        check("sq_nextpc0", actual_nextpc[0], 32'h100C);
        check("sq_nextpc1", actual_nextpc[1], 32'h2000);
        check("sq_pc1", upd_pc[1], 32'h100C);

        // Reset in the middle of a mispredicting resolve
        rst = 1'b1;
        do_resolve(3'd6, 1'b1, 32'h9000);
        tick(); idle();
        rst = 1'b0;
        check("midrst_redirect", 32'(redirect_valid), 32'd0);
        check("midrst_upd", 32'(upd_valid), 32'h0);
        check("midrst_ready", 32'(alloc_ready), 32'd1);
        check("midrst_tag", 32'(alloc_tag[0]), 32'd0);

        // Streaming alloc/resolve/retire through several pointer wraps
        for (int i = 0; i < 22; i++) begin
            idle();
            if (i < 20) set_alloc(0, 32'(32'h3000 + 4 * i), 1'b0, 32'h0);
            if (i >= 1 && i <= 20) do_resolve(3'((i - 1) % 8), 1'b0, 32'h0);
            #1;
            if (i < 20) check("wrap_tag", 32'(alloc_tag[0]), 32'(i % 8));
            tick();
            if (i >= 2) begin
                check("wrap_upd_valid", 32'(upd_valid), 32'h1);
                check("wrap_upd_pc", upd_pc[0], 32'(32'h3000 + 4 * (i - 2)));
                check("wrap_nextpc", actual_nextpc[0], 32'(32'h3004 + 4 * (i - 2)));
            end
        end
        idle();
        tick();
        check("drain_upd", 32'(upd_valid), 32'h0);
        check("drain_ready", 32'(alloc_ready), 32'd1);
`ifdef BRQ_STATS_EN
        check("stat_branches", stat_branches, 32'd20);
`else
        check("stat_branches", stat_branches, 32'd0);
`endif
        check("stat_mispredicts", stat_mispredicts, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
